gme_v2: RTL and testbench

- Parametrised next-generation generic match engine between the parser/key-extract stage and the next pipeline module.
- Buffers MD/PHV per packet and forwards the key to lookup only when the MD target-module field equals LMID.
- Non-matching packets bypass lookup. Lookup indices are merged back into MD in packet order, with the next-module ID rewritten.
- Adds bypass, backpressure-aware emission, statistics ports and an optional lookup timeout.

---
 rtl/gme_pkg.sv | 34 +++
 rtl/gme_v2_if.sv | 60 ++++++
 rtl/gme_sfifo.sv | 70 +++++++
 rtl/gme_v2.sv | 244 ++++++++++++++++++++++++
 tb/tb_gme_v2.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gme_pkg.sv
// -----------------------------------------------------------------------------
// gme_pkg -- shared definitions for the generic match engine (gme_v2).
//
// Contents:
//   * metadata field positions (module-ID byte, lookup-index field, hit flag)
//   * FSM state encoding for the emission controller
//   * statistics counter bundle
// -----------------------------------------------------------------------------
package gme_pkg;

    // Metadata field layout.
    localparam int MID_HI    = 87;   // target/next module ID, high bit
    localparam int MID_LO    = 80;   // target/next module ID, low bit
    localparam int IDX_HI    = 63;   // lookup index field, high bit
    localparam int IDX_LO    = 51;   // lookup index field, low bit
    localparam int HIT_BIT   = 50;   // set when a real lookup index was merged
    localparam int IDX_FLD_W = IDX_HI - IDX_LO + 1;

    // Emission controller states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EMIT = 2'd2
    } gme_state_e;

    // Free-running statistics, all 32-bit and wrapping.
    typedef struct packed {
        logic [31:0] in_pkt;
        logic [31:0] out_pkt;
        logic [31:0] bypass;
        logic [31:0] timeout;
    } gme_stats_t;

endpackage

// File: rtl/gme_v2_if.sv
// -----------------------------------------------------------------------------
// gme_v2_if -- bundle of all gme_v2 data-path signals.
//
// Groups: ingress from the key-extract stage (in_gme_wr/md/phv/key, out_gme_alf),
//         lookup request/response (out_gme_key_wr/key, in_gme_key_alf,
//         in_gme_index_wr/index, out_gme_index_alf),
//         egress to the next module (out_gme_wr/md/phv, in_gme_alf).
//
// Flow control on every channel: a *_wr strobe marks its data valid for that
// single cycle and is never stalled; the receiver instead raises its *_alf
// (almost-full) early enough that the sender stops issuing before space runs
// out. Data issued while the receiver is truly full is dropped.
//
// Modports: slave  = the gme_v2 engine itself
//           master = the surrounding environment (upstream, lookup, downstream)
// -----------------------------------------------------------------------------
interface gme_v2_if #(
    parameter int MD_W  = 256,
    parameter int PHV_W = 1024,
    parameter int KEY_W = 512,
    parameter int IDX_W = 16
);
    logic             in_gme_wr;
    logic [MD_W-1:0]  in_gme_md;
    logic [PHV_W-1:0] in_gme_phv;
    logic [KEY_W-1:0] in_gme_key;
    logic             out_gme_alf;

    logic             out_gme_key_wr;
    logic [KEY_W-1:0] out_gme_key;
    logic             in_gme_key_alf;
    logic             in_gme_index_wr;
    logic [IDX_W-1:0] in_gme_index;
    logic             out_gme_index_alf;

    logic             out_gme_wr;
    logic [MD_W-1:0]  out_gme_md;
    logic [PHV_W-1:0] out_gme_phv;
    logic             in_gme_alf;

    modport slave (
        input  in_gme_wr, in_gme_md, in_gme_phv, in_gme_key,
        output out_gme_alf,
        output out_gme_key_wr, out_gme_key,
        input  in_gme_key_alf, in_gme_index_wr, in_gme_index,
        output out_gme_index_alf,
        output out_gme_wr, out_gme_md, out_gme_phv,
        input  in_gme_alf
    );

    modport master (
        output in_gme_wr, in_gme_md, in_gme_phv, in_gme_key,
        input  out_gme_alf,
        input  out_gme_key_wr, out_gme_key,
        output in_gme_key_alf, in_gme_index_wr, in_gme_index,
        input  out_gme_index_alf,
        input  out_gme_wr, out_gme_md, out_gme_phv,
        output in_gme_alf
    );
endinterface

// File: rtl/gme_sfifo.sv
// -----------------------------------------------------------------------------
// gme_sfifo -- synchronous FIFO with registered read data.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   wr, wdata    push (ignored when full)
//   rd           pop  (ignored when empty); rdata is valid the next cycle
//   rdata        registered read data, 0 after reset
//   usedw        number of stored entries (0..DEPTH)
//   empty, full  status flags
// Simultaneous push and pop are both honoured and leave usedw unchanged.
// -----------------------------------------------------------------------------
module gme_sfifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     rd,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   usedw,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_wr;
    logic             do_rd;

    assign empty = (usedw == '0);
    assign full  = (usedw == FULL_CNT);
    assign do_wr = wr & ~full;
    assign do_rd = rd & ~empty;

    // Storage carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            usedw <= '0;
            rdata <= '0;
        end else begin
            if (do_wr) begin
                wptr <= wptr + 1'b1;
            end
            if (do_rd) begin
                rptr  <= rptr + 1'b1;
                rdata <= mem[rptr];
            end
            case ({do_wr, do_rd})
                2'b10:   usedw <= usedw + 1'b1;
                2'b01:   usedw <= usedw - 1'b1;
                default: usedw <= usedw;
            endcase
        end
    end

endmodule

// File: rtl/gme_v2.sv
// -----------------------------------------------------------------------------
// gme_v2 -- generic match engine.
//
// Buffers {hit, MD, PHV} per packet. Packets whose MD target-module byte equals
// LMID send their key to lookup; the returned index is merged back into MD in
// packet order and the module byte is rewritten to NMID. Other packets bypass
// lookup but still leave in order (a waiting hit packet blocks those behind it).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus             gme_v2_if.slave: ingress, lookup and egress channels
//   stat_in_pkt     accepted packets
//   stat_out_pkt    emitted packets
//   stat_bypass     packets emitted without lookup
//   stat_timeout    packets emitted after a lookup timeout
//   dbg_state       emission controller state
//
// Build option: define GME_LOOKUP_TIMEOUT_EN to give up on a missing index
// after TIMEOUT_CYC eligible cycles; the late index is later discarded.
// Without it, hit packets wait indefinitely and stat_timeout stays 0.
// -----------------------------------------------------------------------------
module gme_v2
    import gme_pkg::*;
#(
    parameter int          MD_W        = 256,
    parameter int          PHV_W       = 1024,
    parameter int          KEY_W       = 512,
    parameter int          IDX_W       = 16,
    parameter int          DEPTH       = 256,
    parameter int          ALF_MARGIN  = 6,
    parameter logic [7:0]  LMID        = 8'd3,
    parameter logic [7:0]  NMID        = 8'd7,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    gme_v2_if.slave     bus,
    output logic [31:0] stat_in_pkt,
    output logic [31:0] stat_out_pkt,
    output logic [31:0] stat_bypass,
    output logic [31:0] stat_timeout,
    output gme_state_e  dbg_state
);
    localparam int          AW     = $clog2(DEPTH);
    localparam int          PKT_W  = 1 + MD_W + PHV_W;
    localparam logic [AW:0] ALF_TH = (AW+1)'(DEPTH - ALF_MARGIN);

    gme_state_e       state;
    gme_stats_t       stats;

    logic             in_hit;
    logic             pkt_wr_ok;
    logic             pkt_rd;
    logic [PKT_W-1:0] pkt_rdata;
    logic [AW:0]      pkt_usedw;
    logic             pkt_empty;
    logic             pkt_full;

    logic             idx_wr;
    logic             idx_rd;
    logic [IDX_W-1:0] idx_rdata;
    logic [AW:0]      idx_usedw;
    logic             idx_empty;
    logic             idx_full_unused;

    logic [DEPTH-1:0] hit_flags;
    logic [AW-1:0]    hit_wptr;
    logic [AW-1:0]    hit_rptr;
    logic             head_hit;

    logic             eligible;
    logic             timeout_fire;
    logic             drop_now;
    logic             to_q;         // packet in flight is a timeout emission
    logic             emit_hit;
    logic [MD_W-1:0]  emit_md;
    logic             idx_hi_unused;

    // ---------------- ingress ----------------
    assign in_hit    = (bus.in_gme_md[MID_HI:MID_LO] == LMID);
    assign pkt_wr_ok = bus.in_gme_wr & ~pkt_full;

    gme_sfifo #(.WIDTH(PKT_W), .DEPTH(DEPTH)) u_pkt_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (bus.in_gme_wr),
        .wdata ({in_hit, bus.in_gme_md, bus.in_gme_phv}),
        .rd    (pkt_rd),
        .rdata (pkt_rdata),
        .usedw (pkt_usedw),
        .empty (pkt_empty),
        .full  (pkt_full)
    );

    // The packet FIFO read is registered, so the head's hit flag is mirrored
    // here to decide eligibility before the head is actually popped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_flags <= '0;
            hit_wptr  <= '0;
            hit_rptr  <= '0;
        end else begin
            if (pkt_wr_ok) begin
                hit_flags[hit_wptr] <= in_hit;
                hit_wptr            <= hit_wptr + 1'b1;
            end
            if (pkt_rd && !pkt_empty) begin
                hit_rptr <= hit_rptr + 1'b1;
            end
        end
    end

    assign head_hit = hit_flags[hit_rptr];

    // ---------------- lookup response ----------------
    assign idx_wr = bus.in_gme_index_wr & ~drop_now;

    gme_sfifo #(.WIDTH(IDX_W), .DEPTH(DEPTH)) u_idx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (idx_wr),
        .wdata (bus.in_gme_index),
        .rd    (idx_rd),
        .rdata (idx_rdata),
        .usedw (idx_usedw),
        .empty (idx_empty),
        .full  (idx_full_unused)
    );

    assign bus.out_gme_alf       = bus.in_gme_key_alf | (pkt_usedw >= ALF_TH);
    assign bus.out_gme_index_alf = (idx_usedw >= ALF_TH);

    // ---------------- optional lookup timeout ----------------
`ifdef GME_LOOKUP_TIMEOUT_EN
    localparam int             WCW       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT_CYC - 1);

    logic [WCW-1:0] wait_cnt;
    logic [AW:0]    drop_pending;
    logic           waiting;

    assign waiting      = (state == IDLE) & ~pkt_empty & ~bus.in_gme_alf & head_hit & idx_empty;
    assign timeout_fire = waiting & (wait_cnt == WAIT_LAST);
    assign drop_now     = bus.in_gme_index_wr & (drop_pending != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt     <= '0;
            drop_pending <= '0;
        end else begin
            if (state == EMIT) begin
                wait_cnt <= '0;
            end else if (waiting && !timeout_fire) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            case ({timeout_fire, drop_now})
                2'b10:   drop_pending <= drop_pending + 1'b1;
                2'b01:   drop_pending <= drop_pending - 1'b1;
                default: drop_pending <= drop_pending;
            endcase
        end
    end
`else
    assign timeout_fire = 1'b0;
    assign drop_now     = 1'b0;
`endif

    // ---------------- emission controller ----------------
    assign eligible = ~pkt_empty & ~bus.in_gme_alf & (~head_hit | ~idx_empty);
    // Pops are issued in READ; the head is still the packet selected in IDLE.
    assign pkt_rd   = (state == READ);
    assign idx_rd   = (state == READ) & head_hit & ~to_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            to_q               <= 1'b0;
            stats              <= '0;
            bus.out_gme_wr     <= 1'b0;
            bus.out_gme_key_wr <= 1'b0;
            bus.out_gme_key    <= '0;
        end else begin
            bus.out_gme_key_wr <= pkt_wr_ok & in_hit;
            if (pkt_wr_ok && in_hit) begin
                bus.out_gme_key <= bus.in_gme_key;
            end
            if (pkt_wr_ok) begin
                stats.in_pkt <= stats.in_pkt + 32'd1;
            end

            bus.out_gme_wr <= 1'b0;
            case (state)
                IDLE: begin
                    if (eligible) begin
                        state <= READ;
                        to_q  <= 1'b0;
                    end else if (timeout_fire) begin
                        state <= READ;
                        to_q  <= 1'b1;
                    end
                end
                READ: begin
                    state          <= EMIT;
                    bus.out_gme_wr <= 1'b1;
                end
                EMIT: begin
                    state         <= IDLE;
                    stats.out_pkt <= stats.out_pkt + 32'd1;
                    if (!emit_hit) begin
                        stats.bypass <= stats.bypass + 32'd1;
                    end
                    if (to_q) begin
                        stats.timeout <= stats.timeout + 32'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Egress data comes straight from the FIFO read registers (valid in EMIT
    // and held afterwards); both reset to 0, so the outputs do too.
    assign emit_hit = pkt_rdata[PKT_W-1];

    always_comb begin
        emit_md = pkt_rdata[PHV_W +: MD_W];
        if (emit_hit) begin
            emit_md[MID_HI:MID_LO] = NMID;
            emit_md[IDX_HI:IDX_LO] = to_q ? '0 : idx_rdata[IDX_FLD_W-1:0];
            emit_md[HIT_BIT]       = ~to_q;
        end
    end

    assign idx_hi_unused   = ^idx_rdata[IDX_W-1:IDX_FLD_W];
    assign bus.out_gme_md  = emit_md;
    assign bus.out_gme_phv = pkt_rdata[PHV_W-1:0];

    assign stat_in_pkt  = stats.in_pkt;
    assign stat_out_pkt = stats.out_pkt;
    assign stat_bypass  = stats.bypass;
    assign stat_timeout = stats.timeout;
    assign dbg_state    = state;

endmodule

// File: tb/tb_gme_v2.sv
// -----------------------------------------------------------------------------
// tb_gme_v2 -- directed bench for gme_v2 (default build, no lookup timeout).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gme_v2;
    import gme_pkg::*;

    localparam int MD_W       = 256;
    localparam int PHV_W      = 1024;
    localparam int KEY_W      = 512;
    localparam int IDX_W      = 16;
    localparam int DEPTH      = 256;
    localparam int ALF_MARGIN = 6;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    gme_v2_if #(.MD_W(MD_W), .PHV_W(PHV_W), .KEY_W(KEY_W), .IDX_W(IDX_W)) bus ();

    logic [31:0] stat_in_pkt;
    logic [31:0] stat_out_pkt;
    logic [31:0] stat_bypass;
    logic [31:0] stat_timeout;
    gme_state_e  dbg_state;

    gme_v2 #(
        .MD_W(MD_W), .PHV_W(PHV_W), .KEY_W(KEY_W), .IDX_W(IDX_W),
        .DEPTH(DEPTH), .ALF_MARGIN(ALF_MARGIN),
        .LMID(8'd3), .NMID(8'd7), .TIMEOUT_CYC(1024)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .stat_in_pkt  (stat_in_pkt),
        .stat_out_pkt (stat_out_pkt),
        .stat_bypass  (stat_bypass),
        .stat_timeout (stat_timeout),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [MD_W+PHV_W-1:0] exp_q[$];
    logic [KEY_W-1:0]      key_q[$];
    int                    emit_cyc[$];
    int                    n_cmp  = 0;
    int                    n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Metadata built from fields: tag-derived filler, module byte, index field, hit bit.
    function automatic logic [MD_W-1:0] mk_md(input logic [7:0] mid, input logic [12:0] idx,
                                              input logic hit, input logic [31:0] tag);
        logic [MD_W-1:0] m;
        m                 = '0;
        m[MD_W-1 -: 32]   = tag ^ 32'hA5A5_0000;
        m[87:80]          = mid;
        m[79:64]          = 16'hBEEF ^ tag[15:0];
        m[63:51]          = idx;
        m[50]             = hit;
        m[49:0]           = {18'h0, tag};
        return m;
    endfunction

    function automatic logic [PHV_W-1:0] mk_phv(input logic [31:0] tag);
        return {16{tag, ~tag}};
    endfunction

    function automatic logic [KEY_W-1:0] mk_key(input logic [31:0] tag);
        return {16{tag ^ 32'h0F0F_0F0F}};
    endfunction

    // ---------------- driver tasks (enter and leave at posedge + 1) ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [MD_W-1:0] md, input logic [31:0] tag,
                        input bit push_exp, input logic [MD_W-1:0] exp_md);
        if (push_exp) exp_q.push_back({exp_md, mk_phv(tag)});
        if (md[87:80] == 8'd3) key_q.push_back(mk_key(tag));
        bus.in_gme_wr  = 1'b1;
        bus.in_gme_md  = md;
        bus.in_gme_phv = mk_phv(tag);
        bus.in_gme_key = mk_key(tag);
        tick(1);
        bus.in_gme_wr  = 1'b0;
    endtask

    task automatic send_idx(input logic [IDX_W-1:0] idx);
        bus.in_gme_index_wr = 1'b1;
        bus.in_gme_index    = idx;
        tick(1);
        bus.in_gme_index_wr = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || key_q.size() != 0) && k < budget) begin
            tick(1);
            k++;
        end
        check(name, 64'(exp_q.size() + key_q.size()), 64'd0);
        tick(4);
    endtask

    // ---------------- main sequence + monitor ----------------
    logic [MD_W+PHV_W-1:0] got_pkt;
    logic [MD_W+PHV_W-1:0] want_pkt;
    logic [KEY_W-1:0]      want_key;
    logic [31:0]           tag;
    int                    drv;

    initial begin
        bus.in_gme_wr       = 1'b0;
        bus.in_gme_md       = '0;
        bus.in_gme_phv      = '0;
        bus.in_gme_key      = '0;
        bus.in_gme_key_alf  = 1'b0;
        bus.in_gme_index_wr = 1'b0;
        bus.in_gme_index    = '0;
        bus.in_gme_alf      = 1'b0;

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (rst_n && bus.out_gme_wr) begin
                        emit_cyc.push_back(cyc);
                        n_cmp++;
                        got_pkt = {bus.out_gme_md, bus.out_gme_phv};
                        if (exp_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL emit_unexpected: got md=%h, required no emission",
                                     bus.out_gme_md[95:0]);
                        end else begin
                            want_pkt = exp_q.pop_front();
                            if (got_pkt !== want_pkt) begin
                                n_fail++;
                                $display("FAIL emit_data: got md=%h phv=%h, required md=%h phv=%h",
                                         got_pkt[PHV_W+95:PHV_W], got_pkt[31:0],
                                         want_pkt[PHV_W+95:PHV_W], want_pkt[31:0]);
                            end
                        end
                    end
                    if (rst_n && bus.out_gme_key_wr) begin
                        n_cmp++;
                        if (key_q.size() == 0) begin
                            n_fail++;
                            $display("FAIL key_unexpected: got key=%h, required no key write",
                                     bus.out_gme_key[63:0]);
                        end else begin
                            want_key = key_q.pop_front();
                            if (bus.out_gme_key !== want_key) begin
                                n_fail++;
                                $display("FAIL key_data: got %h, required %h",
                                         bus.out_gme_key[63:0], want_key[63:0]);
                            end
                        end
                    end
                end
            end
            begin : stimulus
                // Reset state
                tick(3);
                check("rst_out_wr",    64'(bus.out_gme_wr), 64'd0);
                check("rst_key_wr",    64'(bus.out_gme_key_wr), 64'd0);
                check("rst_key",       bus.out_gme_key[63:0], 64'd0);
                check("rst_md",        bus.out_gme_md[63:0], 64'd0);
                check("rst_phv",       bus.out_gme_phv[63:0], 64'd0);
                check("rst_alf",       64'(bus.out_gme_alf), 64'd0);
                check("rst_idx_alf",   64'(bus.out_gme_index_alf), 64'd0);
                check("rst_stat_in",   64'(stat_in_pkt), 64'd0);
                check("rst_stat_out",  64'(stat_out_pkt), 64'd0);
                check("rst_stat_byp",  64'(stat_bypass), 64'd0);
                check("rst_stat_to",   64'(stat_timeout), 64'd0);
                check("rst_state",     64'(dbg_state), 64'(IDLE));
                rst_n = 1'b1;
                tick(2);

                // Single hit, index 0x1ABC five cycles later
                emit_cyc.delete();
                tag = 32'h1111_0001;
                send(mk_md(8'd3, 13'h1555, 1'b0, tag), tag, 1'b1, mk_md(8'd7, 13'h1ABC, 1'b1, tag));
                tick(4);
                drv = cyc;
                send_idx(16'h1ABC);
                wait_drain(50, "t1_drain");
                check("t1_emits",     64'(emit_cyc.size()), 64'd1);
                if (emit_cyc.size() == 1) check("t1_latency", 64'(emit_cyc[0]), 64'(drv + 3));
                check("t1_md_mid",    64'(bus.out_gme_md[87:80]), 64'h07);
                check("t1_md_idx",    64'(bus.out_gme_md[63:51]), 64'h1ABC);
                check("t1_md_hit",    64'(bus.out_gme_md[50]), 64'd1);
                check("t1_stat_in",   64'(stat_in_pkt), 64'd1);
                check("t1_stat_out",  64'(stat_out_pkt), 64'd1);
                check("t1_stat_byp",  64'(stat_bypass), 64'd0);

                // Three back-to-back bypass packets
                emit_cyc.delete();
                drv = cyc;
                for (int i = 0; i < 3; i++) begin
                    tag = 32'h2222_0000 + i;
                    send(mk_md(8'd5, 13'h0AAA, 1'b1, tag), tag, 1'b1, mk_md(8'd5, 13'h0AAA, 1'b1, tag));
                end
                wait_drain(50, "t2_drain");
                check("t2_emits", 64'(emit_cyc.size()), 64'd3);
                if (emit_cyc.size() == 3) begin
                    check("t2_first_latency", 64'(emit_cyc[0]), 64'(drv + 3));
                    check("t2_gap0", 64'(emit_cyc[1] - emit_cyc[0]), 64'd3);
                    check("t2_gap1", 64'(emit_cyc[2] - emit_cyc[1]), 64'd3);
                end
                check("t2_stat_byp", 64'(stat_bypass), 64'd3);
                check("t2_stat_out", 64'(stat_out_pkt), 64'd4);
                check("t2_stat_in",  64'(stat_in_pkt), 64'd4);

                // Hit then bypass, index 20 cycles late: the hit blocks the bypass
                emit_cyc.delete();
                tag = 32'h3333_0003;
                send(mk_md(8'd3, 13'h0000, 1'b1, tag), tag, 1'b1, mk_md(8'd7, 13'h0042, 1'b1, tag));
                tag = 32'h3333_0004;
                send(mk_md(8'd9, 13'h1FFF, 1'b0, tag), tag, 1'b1, mk_md(8'd9, 13'h1FFF, 1'b0, tag));
                tick(19);
                check("t3_no_early_emit", 64'(emit_cyc.size()), 64'd0);
                drv = cyc;
                send_idx(16'h0042);
                wait_drain(50, "t3_drain");
                check("t3_emits", 64'(emit_cyc.size()), 64'd2);
                if (emit_cyc.size() == 2) begin
                    check("t3_hit_cyc",    64'(emit_cyc[0]), 64'(drv + 3));
                    check("t3_bypass_cyc", 64'(emit_cyc[1]), 64'(drv + 6));
                end
                check("t3_stat_out", 64'(stat_out_pkt), 64'd6);
                check("t3_stat_byp", 64'(stat_bypass), 64'd4);

                // Fill DEPTH-6 packets under downstream backpressure, then drain
                emit_cyc.delete();
                bus.in_gme_alf = 1'b1;
                for (int i = 0; i < DEPTH - ALF_MARGIN; i++) begin
                    tag = 32'h4000_0000 + i;
                    send(mk_md(8'd5, 13'h0123, 1'b0, tag), tag, 1'b1, mk_md(8'd5, 13'h0123, 1'b0, tag));
                    if (i == DEPTH - ALF_MARGIN - 2) check("t4_alf_at_249", 64'(bus.out_gme_alf), 64'd0);
                    if (i == DEPTH - ALF_MARGIN - 1) check("t4_alf_at_250", 64'(bus.out_gme_alf), 64'd1);
                end
                tick(5);
                check("t4_held_emits", 64'(emit_cyc.size()), 64'd0);
                check("t4_held_stat",  64'(stat_out_pkt), 64'd6);
                check("t4_idx_alf",    64'(bus.out_gme_index_alf), 64'd0);
                bus.in_gme_alf = 1'b0;
                wait_drain(1000, "t4_drain");
                check("t4_emits",    64'(emit_cyc.size()), 64'd250);
                check("t4_stat_in",  64'(stat_in_pkt), 64'd256);
                check("t4_stat_out", 64'(stat_out_pkt), 64'd256);
                check("t4_alf_low",  64'(bus.out_gme_alf), 64'd0);

                // Reset with four packets queued
                bus.in_gme_alf = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    tag = 32'h5000_0000 + i;
                    send(mk_md(8'd5, 13'h0001, 1'b0, tag), tag, 1'b0, '0);
                end
                tick(1);
                #2 rst_n = 1'b0;
                #1;
                check("t5_key",      bus.out_gme_key[63:0], 64'd0);
                check("t5_md",       bus.out_gme_md[63:0], 64'd0);
                check("t5_phv",      bus.out_gme_phv[63:0], 64'd0);
                check("t5_out_wr",   64'(bus.out_gme_wr), 64'd0);
                check("t5_stat_in",  64'(stat_in_pkt), 64'd0);
                check("t5_stat_out", 64'(stat_out_pkt), 64'd0);
                check("t5_stat_byp", 64'(stat_bypass), 64'd0);
                @(posedge clk);
                #1;
                rst_n          = 1'b1;
                bus.in_gme_alf = 1'b0;
                emit_cyc.delete();
                tick(20);
                check("t5_no_emit",  64'(emit_cyc.size()), 64'd0);
                check("t5_state",    64'(dbg_state), 64'(IDLE));

                // Index arriving ahead of its hit packet
                emit_cyc.delete();
                send_idx(16'h0777);
                tag = 32'h6666_0006;
                drv = cyc;
                send(mk_md(8'd3, 13'h0ABC, 1'b0, tag), tag, 1'b1, mk_md(8'd7, 13'h0777, 1'b1, tag));
                wait_drain(50, "t6_drain");
                if (emit_cyc.size() == 1) check("t6_latency", 64'(emit_cyc[0]), 64'(drv + 3));
                check("t6_stat_in",  64'(stat_in_pkt), 64'd1);
                check("t6_stat_out", 64'(stat_out_pkt), 64'd1);
                check("t6_stat_to",  64'(stat_timeout), 64'd0);
            end
        join_any

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
